// File: rtl/logic_arb_8.sv
`default_nettype none
// ============================================================================
// Module   : logic_arb_8
// Purpose  : Two-requester arbiter that runs each job through one logic_8 ALU.
//            The LOGIC_ARB_RR_EN macro selects round-robin grants; when it is
//            undefined, requester 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================

module logic_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] y,
    output logic       illegal
);
    always_comb begin
        y       = 8'h00;
        illegal = 1'b0;
        case (op)
            3'b000:  y = ~a;
            3'b001:  y = a & b;
            3'b010:  y = a | b;
            3'b011:  y = ~(a & b);
            3'b100:  y = {a[6:0], a[7]};
            3'b101:  y = {a[0], a[7:1]};
            default: illegal = 1'b1;
        endcase
    end
endmodule

module logic_arb_8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       Req0Valid,
    output logic       Req0Ready,
    input  logic [7:0] Req0A,
    input  logic [7:0] Req0B,
    input  logic [2:0] Req0Op,
    input  logic [2:0] Req0Cnt,
    input  logic       Req1Valid,
    output logic       Req1Ready,
    input  logic [7:0] Req1A,
    input  logic [7:0] Req1B,
    input  logic [2:0] Req1Op,
    input  logic [2:0] Req1Cnt,
    output logic       RspValid,
    input  logic       RspReady,
    output logic [7:0] RspResult,
    output logic       RspId,
    output logic       RspErr
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [2:0] r_op;
    logic [2:0] r_cnt;
    logic       r_id;
    logic [7:0] r_result;
    logic       r_err;

    logic       w_gnt;
    logic       w_hs;
    logic       w_rot;
    logic       w_exec_done;
    logic [7:0] w_y;
    logic       w_illegal;

`ifdef LOGIC_ARB_RR_EN
    logic r_ptr;
    // With both requesters pending, the pointer names the one not served last.
    assign w_gnt = (Req0Valid && Req1Valid) ? r_ptr : Req1Valid;
`else
    assign w_gnt = !Req0Valid;
`endif

    assign Req0Ready = (r_state == IDLE) && !rst && !w_gnt && Req0Valid;
    assign Req1Ready = (r_state == IDLE) && !rst &&  w_gnt && Req1Valid;
    assign w_hs      = Req0Ready || Req1Ready;

    assign w_rot       = (r_op == 3'b100) || (r_op == 3'b101);
    assign w_exec_done = !(w_rot && (r_cnt > 3'd1));

    logic_8 u_alu (
        .a       (r_a),
        .b       (r_b),
        .op      (r_op),
        .y       (w_y),
        .illegal (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_next = EXEC;
            EXEC:    if (w_exec_done) w_next = RESP;
            RESP:    if (RspReady) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_op     <= 3'b000;
            r_cnt    <= 3'd0;
            r_id     <= 1'b0;
            r_result <= 8'h00;
            r_err    <= 1'b0;
`ifdef LOGIC_ARB_RR_EN
            r_ptr    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_a   <= w_gnt ? Req1A   : Req0A;
                        r_b   <= w_gnt ? Req1B   : Req0B;
                        r_op  <= w_gnt ? Req1Op  : Req0Op;
                        r_cnt <= w_gnt ? Req1Cnt : Req0Cnt;
                        r_id  <= w_gnt;
`ifdef LOGIC_ARB_RR_EN
                        r_ptr <= !w_gnt;
`endif
                    end
                end
                EXEC: begin
                    if (!w_exec_done) begin
                        // Multi-step rotate: feed the rotate-by-1 result back.
                        r_a   <= w_y;
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_err <= w_illegal;
                        if (w_illegal)
                            r_result <= 8'h00;
                        else if (w_rot && (r_cnt == 3'd0))
                            r_result <= r_a;
                        else
                            r_result <= w_y;
                    end
                end
                default: ;
            endcase
        end
    end

    assign RspValid  = (r_state == RESP);
    assign RspResult = RspValid ? r_result : 8'h00;
    assign RspId     = RspValid ? r_id     : 1'b0;
    assign RspErr    = RspValid ? r_err    : 1'b0;
endmodule

`default_nettype wire

// File: tb/tb_logic_arb_8.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_arb_8
// Purpose  : Self-checking bench for logic_arb_8 against a job-level model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_logic_arb_8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Req0Valid = 1'b0, Req1Valid = 1'b0;
    logic       Req0Ready, Req1Ready;
    logic [7:0] Req0A = 8'h00, Req0B = 8'h00, Req1A = 8'h00, Req1B = 8'h00;
    logic [2:0] Req0Op = 3'd0, Req0Cnt = 3'd0, Req1Op = 3'd0, Req1Cnt = 3'd0;
    logic       RspValid, RspReady = 1'b1;
    logic [7:0] RspResult;
    logic       RspId, RspErr;

    logic_arb_8 dut (
        .clk(clk), .rst(rst),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0A(Req0A), .Req0B(Req0B),
        .Req0Op(Req0Op), .Req0Cnt(Req0Cnt),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1A(Req1A), .Req1B(Req1B),
        .Req1Op(Req1Op), .Req1Cnt(Req1Cnt),
        .RspValid(RspValid), .RspReady(RspReady), .RspResult(RspResult),
        .RspId(RspId), .RspErr(RspErr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Job-level model: one job at a time, response due a fixed latency later.
    bit       m_busy = 1'b0;
    int       m_rsp_at = 0;
    bit [7:0] m_res = 8'h00;
    bit       m_id = 1'b0, m_err = 1'b0, m_ptr = 1'b0;

    function automatic logic [7:0] calc(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op, input logic [2:0] cnt);
        int n;
        n = int'(cnt);
        case (op)
            3'd0:    return ~a;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return ~(a & b);
            3'd4:    return 8'((a << n) | (a >> (8 - n)));
            3'd5:    return 8'((a >> n) | (a << (8 - n)));
            default: return 8'h00;
        endcase
    endfunction

    function automatic int lat(input logic [2:0] op, input logic [2:0] cnt);
        if (op == 3'd4 || op == 3'd5) return 1 + ((cnt == 3'd0) ? 1 : int'(cnt));
        return 2;
    endfunction

    function automatic bit gnt(input logic v0, input logic v1, input bit ptr);
        if (v0 && v1) begin
`ifdef LOGIC_ARB_RR_EN
            return ptr;
`else
            return 1'b0;
`endif
        end
        return v1 && !v0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin : model
        bit g;
        if (rst) begin
            m_busy = 1'b0;
            m_ptr  = 1'b0;
        end else if (m_busy) begin
            if (cyc >= m_rsp_at && RspReady) m_busy = 1'b0;
        end else begin
            g = gnt(Req0Valid, Req1Valid, m_ptr);
            if (g ? Req1Valid : Req0Valid) begin
                m_id     = g;
                m_err    = g ? (Req1Op > 3'd5) : (Req0Op > 3'd5);
                m_res    = g ? calc(Req1A, Req1B, Req1Op, Req1Cnt)
                             : calc(Req0A, Req0B, Req0Op, Req0Cnt);
                m_rsp_at = cyc + (g ? lat(Req1Op, Req1Cnt) : lat(Req0Op, Req0Cnt));
                m_busy   = 1'b1;
`ifdef LOGIC_ARB_RR_EN
                m_ptr    = !g;
`endif
            end
        end
        cyc++;
    end

    always @(negedge clk) begin : compare
        bit ev, g;
        if (cyc >= 1) begin
            ev = m_busy && (cyc >= m_rsp_at);
            g  = gnt(Req0Valid, Req1Valid, m_ptr);
            chk("Req0Ready", Req0Ready, !m_busy && !rst && !g && Req0Valid);
            chk("Req1Ready", Req1Ready, !m_busy && !rst &&  g && Req1Valid);
            chk("RspValid",  RspValid,  ev);
            chk("RspResult", RspResult, ev ? m_res : 8'h00);
            chk("RspId",     RspId,     ev ? m_id  : 1'b0);
            chk("RspErr",    RspErr,    ev ? m_err : 1'b0);
        end
    end

    task automatic drive(input bit id, input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [2:0] cnt);
        if (id) begin Req1Valid = v; Req1A = a; Req1B = b; Req1Op = op; Req1Cnt = cnt; end
        else    begin Req0Valid = v; Req0A = a; Req0B = b; Req0Op = op; Req0Cnt = cnt; end
    endtask

    task automatic job(input bit id, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [2:0] cnt,
                       input logic [7:0] exp_res, input bit exp_err, input int exp_lat);
        int t;
        bit got;
        @(posedge clk); #1;
        RspReady = 1'b1;
        drive(id, 1'b1, a, b, op, cnt);
        t = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id ? Req1Ready : Req0Ready) begin t = cyc; break; end
        end
        if (t < 0) begin
            chk("job_grant_timeout", 0, 1);
            @(posedge clk); #1;
            drive(id, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
        end else begin
            @(posedge clk); #1;
            drive(id, 1'b0, 8'($urandom), 8'($urandom), 3'($urandom), 3'($urandom));
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (RspValid) begin got = 1'b1; break; end
            end
            if (!got) chk("job_rsp_timeout", 0, 1);
            else begin
                chk("job_latency", cyc - t, exp_lat);
                chk("job_result",  RspResult, exp_res);
                chk("job_id",      RspId, id);
                chk("job_err",     RspErr, exp_err);
            end
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int t;
        bit seen, g, found;
        bit exp_g [4];
`ifdef LOGIC_ARB_RR_EN
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", RspValid, 1'b0);
        chk("reset_rsp_result", RspResult, 8'h00);

        // Directed literal jobs.
        job(1'b0, 8'hF0, 8'hAA, 3'd1, 3'd0, 8'hA0, 1'b0, 2);
        job(1'b0, 8'hF0, 8'hAA, 3'd0, 3'd0, 8'h0F, 1'b0, 2);
        job(1'b0, 8'hF0, 8'hAA, 3'd2, 3'd0, 8'hFA, 1'b0, 2);
        job(1'b0, 8'hF0, 8'hAA, 3'd3, 3'd0, 8'h5F, 1'b0, 2);
        job(1'b1, 8'h81, 8'h00, 3'd4, 3'd3, 8'h0C, 1'b0, 4);
        job(1'b1, 8'h81, 8'h00, 3'd5, 3'd2, 8'h60, 1'b0, 3);
        job(1'b1, 8'h81, 8'h00, 3'd5, 3'd0, 8'h81, 1'b0, 2);
        job(1'b0, 8'h3C, 8'h55, 3'd6, 3'd4, 8'h00, 1'b1, 2);
        job(1'b1, 8'hFF, 8'hFF, 3'd7, 3'd0, 8'h00, 1'b1, 2);

        // Back-pressure: response held while a new request waits.
        @(posedge clk); #1;
        RspReady = 1'b0;
        drive(1'b0, 1'b1, 8'hF0, 8'hAA, 3'd1, 3'd0);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (RspValid) begin found = 1'b1; break; end
        end
        chk("stall_rsp_seen", found, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid",  RspValid, 1'b1);
            chk("stall_result", RspResult, 8'hA0);
            chk("stall_ready0", Req0Ready, 1'b0);
        end
        @(posedge clk); #1 RspReady = 1'b1;
        @(negedge clk);
        chk("release_valid", RspValid, 1'b1);
        @(negedge clk);
        chk("release_idle_valid", RspValid, 1'b0);
        chk("release_idle_ready", Req0Ready, 1'b1);
        @(posedge clk); #1 drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
        idle_cycles(6);

        // Arbitration with both requesters continuously valid.
        pulse_reset();
        drive(1'b0, 1'b1, 8'h12, 8'h34, 3'd1, 3'd0);
        drive(1'b1, 1'b1, 8'h56, 8'h78, 3'd2, 3'd0);
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (Req0Ready || Req1Ready) begin found = 1'b1; g = Req1Ready; break; end
            end
            if (!found) chk("arb_timeout", 0, 1);
            else        chk("arb_grant", g, exp_g[k]);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
        idle_cycles(6);

        // Reset in the 3rd EXEC cycle of a 5-step rotate.
        @(posedge clk); #1 drive(1'b0, 1'b1, 8'hC3, 8'h00, 3'd4, 3'd5);
        t = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (Req0Ready) begin t = cyc; break; end
        end
        if (t < 0) chk("abort_grant_timeout", 0, 1);
        @(posedge clk); #1 drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (RspValid) seen = 1'b1;
        end
        chk("abort_no_rsp", seen, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 8'h0F, 8'hF0, 3'd2, 3'd0);
        drive(1'b1, 1'b1, 8'h11, 8'h22, 3'd1, 3'd0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (Req0Ready || Req1Ready) begin found = 1'b1; g = Req1Ready; break; end
        end
        if (!found) chk("post_rst_timeout", 0, 1);
        else        chk("post_rst_grant", g, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
        idle_cycles(6);

        // Randomized traffic, inputs changing every cycle.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 63) == 0);
            RspReady  = ($urandom_range(0, 3) != 0);
            drive(1'b0, 1'($urandom), 8'($urandom), 8'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            drive(1'b1, 1'($urandom), 8'($urandom), 8'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        RspReady = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
        idle_cycles(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
